// File: rtl/powerup_spawner_if.sv
// Game-side bundle for the power-up spawner: play/ball inputs in, power-up state out.
interface powerup_spawner_if;
  logic       game_active_i;
  logic [9:0] ball_x_i;
  logic [9:0] ball_y_i;
  logic       pp_visible_o;
  logic [9:0] pp_x_o;
  logic [9:0] pp_y_o;
  logic       eaten_o;
  logic [1:0] mode_o;

  modport master (
    output game_active_i, ball_x_i, ball_y_i,
    input  pp_visible_o, pp_x_o, pp_y_o, eaten_o, mode_o
  );

  modport slave (
    input  game_active_i, ball_x_i, ball_y_i,
    output pp_visible_o, pp_x_o, pp_y_o, eaten_o, mode_o
  );
endinterface

// File: rtl/powerup_spawner.sv
// Power-up spawner: waits RESPAWN_SEC, places a square at an LFSR position, reports when the ball eats it.
// Build macro PP_LIFETIME_EN: an uneaten power-up disappears after LIFETIME_SEC seconds.
module powerup_spawner #(
  parameter int PRESCALER    = 64999999,
  parameter int RESPAWN_SEC  = 5,
  parameter int LIFETIME_SEC = 8,
  parameter int PP_SIZE      = 16,
  parameter int BALL_SIZE    = 8,
  parameter int X_MIN        = 64,
  parameter int Y_MIN        = 32
) (
  input logic              clk,
  input logic              reset,
  powerup_spawner_if.slave bus
);

  localparam int            PW        = (PRESCALER > 0) ? $clog2(PRESCALER + 1) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALER);
  localparam logic [15:0]   LFSR_SEED = 16'hACE1;
  localparam logic [15:0]   LFSR_TAPS = 16'hB400;
`ifdef PP_LIFETIME_EN
  localparam logic          LIFETIME_EN = 1'b1;
`else
  localparam logic          LIFETIME_EN = 1'b0;
`endif

  typedef enum logic [1:0] {WAIT, PLACE, SHOW, EAT} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    sec_q, sec_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          vis_q, vis_d;
  logic          eaten_q, eaten_d;
  logic [1:0]    mode_q, mode_d;
  logic [9:0]    ppX_q, ppX_d;
  logic [9:0]    ppY_q, ppY_d;

  logic        tick, respawnDue, lifetimeDue, collision;
  logic [10:0] ballX, ballY, ppX, ppY;

  assign tick        = (presc_q == PRESC_MAX);
  assign respawnDue  = tick && ((sec_q + 4'd1) == 4'(RESPAWN_SEC));
  assign lifetimeDue = tick && ((sec_q + 4'd1) == 4'(LIFETIME_SEC));

  // Overlap test widened to 11 bits so the right/bottom edges cannot wrap.
  assign ballX = {1'b0, bus.ball_x_i};
  assign ballY = {1'b0, bus.ball_y_i};
  assign ppX   = {1'b0, ppX_q};
  assign ppY   = {1'b0, ppY_q};
  assign collision = (ballX < ppX + 11'(PP_SIZE)) && (ballX + 11'(BALL_SIZE) > ppX) &&
                     (ballY < ppY + 11'(PP_SIZE)) && (ballY + 11'(BALL_SIZE) > ppY);

  always_comb begin
    state_d = state_q;
    lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    ppX_d   = ppX_q;
    ppY_d   = ppY_q;
    mode_d  = mode_q;
    presc_d = presc_q;
    sec_d   = sec_q;

    case (state_q)
      WAIT: if (respawnDue) state_d = PLACE;
      PLACE: begin
        state_d = SHOW;
        ppX_d   = 10'(X_MIN) + {2'b00, lfsr_q[7:0]};
        ppY_d   = 10'(Y_MIN) + {2'b00, lfsr_q[15:8]};
        mode_d  = lfsr_q[1:0] ^ lfsr_q[9:8];
      end
      SHOW: begin
        if (collision) state_d = EAT;
        else if (LIFETIME_EN && lifetimeDue) state_d = WAIT;
      end
      EAT:     state_d = WAIT;
      default: state_d = WAIT;
    endcase

    if (!bus.game_active_i) state_d = WAIT;

    // Second timing restarts on every state entry and stays cleared while play is paused.
    if ((state_d != state_q) || !bus.game_active_i) begin
      presc_d = '0;
      sec_d   = '0;
    end else if (tick) begin
      presc_d = '0;
      sec_d   = sec_q + 4'd1;
    end else begin
      presc_d = presc_q + 1'b1;
    end

    vis_d   = (state_d == SHOW);
    eaten_d = (state_d == EAT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT;
      presc_q <= '0;
      sec_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      vis_q   <= 1'b0;
      eaten_q <= 1'b0;
      mode_q  <= '0;
      ppX_q   <= '0;
      ppY_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sec_q   <= sec_d;
      lfsr_q  <= lfsr_d;
      vis_q   <= vis_d;
      eaten_q <= eaten_d;
      mode_q  <= mode_d;
      ppX_q   <= ppX_d;
      ppY_q   <= ppY_d;
    end
  end

  assign bus.pp_visible_o = vis_q;
  assign bus.eaten_o      = eaten_q;
  assign bus.mode_o       = mode_q;
  assign bus.pp_x_o       = ppX_q;
  assign bus.pp_y_o       = ppY_q;

endmodule

// File: tb/tb_powerup_spawner.sv
// Scoreboard bench for powerup_spawner: stimulus queues expected placements/eats, a negedge monitor checks them.
module tb_powerup_spawner;

  localparam int PRESCALER    = 3;
  localparam int RESPAWN_SEC  = 2;
  localparam int LIFETIME_SEC = 3;
  localparam int PP_SIZE      = 16;
  localparam int BALL_SIZE    = 8;
  localparam int X_MIN        = 64;
  localparam int Y_MIN        = 32;
  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] mode;
  } place_t;

  logic        clk = 1'b0;
  logic        reset;
  int          assertCount = 0;
  int          failCount = 0;
  logic [15:0] modelLfsr;
  logic        prevVisible = 1'b0;
  place_t      placeQ[$];
  logic [1:0]  eatQ[$];
  place_t      lastPlace, nextPlace, monExp;
  int          visCount;

  powerup_spawner_if bus();

  powerup_spawner #(
    .PRESCALER(PRESCALER), .RESPAWN_SEC(RESPAWN_SEC), .LIFETIME_SEC(LIFETIME_SEC),
    .PP_SIZE(PP_SIZE), .BALL_SIZE(BALL_SIZE), .X_MIN(X_MIN), .Y_MIN(Y_MIN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] stepN(input logic [15:0] v, input int n);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {1'b0, r[15:1]} ^ (r[0] ? 16'hB400 : 16'h0000);
    return r;
  endfunction

  function automatic place_t placeFrom(input logic [15:0] l);
    place_t p;
    p.x    = 10'(X_MIN) + {2'b00, l[7:0]};
    p.y    = 10'(Y_MIN) + {2'b00, l[15:8]};
    p.mode = l[1:0] ^ l[9:8];
    return p;
  endfunction

  // Reference LFSR: tracks the value the DUT register should hold in each cycle.
  always @(posedge clk) begin
    if (reset) modelLfsr <= SEED;
    else       modelLfsr <= stepN(modelLfsr, 1);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic act, input logic [9:0] bx, input logic [9:0] by);
    bus.game_active_i = act;
    bus.ball_x_i      = bx;
    bus.ball_y_i      = by;
  endtask

  task automatic waitVisible(input string name, input int expCycles);
    int n;
    n = 0;
    while (bus.pp_visible_o !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 32'(n), 32'(expCycles));
  endtask

  // Monitor: every eaten pulse and every pp_visible rise must match the head of its queue.
  always @(negedge clk) begin
    if (bus.eaten_o === 1'b1) begin
      if (eatQ.size() == 0) checkOutput("unexpectedEaten", 32'(bus.eaten_o), 0);
      else                  checkOutput("eatenMode", 32'(bus.mode_o), 32'(eatQ.pop_front()));
      checkOutput("eatenHidesPp", 32'(bus.pp_visible_o), 0);
    end
    if (bus.pp_visible_o === 1'b1 && prevVisible !== 1'b1) begin
      if (placeQ.size() == 0) begin
        checkOutput("unexpectedPlace", 32'(bus.pp_visible_o), 0);
      end else begin
        monExp = placeQ.pop_front();
        checkOutput("placeX", 32'(bus.pp_x_o), 32'(monExp.x));
        checkOutput("placeY", 32'(bus.pp_y_o), 32'(monExp.y));
        checkOutput("placeMode", 32'(bus.mode_o), 32'(monExp.mode));
      end
    end
    prevVisible <= bus.pp_visible_o;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    applyStimulus(1'b1, 10'd1000, 10'd1000);
    repeat (3) @(negedge clk);
    checkOutput("rstVisible", 32'(bus.pp_visible_o), 0);
    checkOutput("rstEaten", 32'(bus.eaten_o), 0);
    checkOutput("rstPpX", 32'(bus.pp_x_o), 0);
    checkOutput("rstPpY", 32'(bus.pp_y_o), 0);
    checkOutput("rstMode", 32'(bus.mode_o), 0);

    // 8 WAIT cycles then PLACE, which sees the seed advanced 8 times
    reset = 1'b0;
    lastPlace = placeFrom(stepN(SEED, 8));
    placeQ.push_back(lastPlace);
    waitVisible("visAfterReset", 9);

    // centre hit
    applyStimulus(1'b1, lastPlace.x + 10'd4, lastPlace.y + 10'd4);
    eatQ.push_back(lastPlace.mode);
    nextPlace = placeFrom(stepN(modelLfsr, 10));
    placeQ.push_back(nextPlace);
    @(negedge clk);
    checkOutput("eatenRise", 32'(bus.eaten_o), 1);
    checkOutput("visDuringEat", 32'(bus.pp_visible_o), 0);
    checkOutput("modeHeld", 32'(bus.mode_o), 32'(lastPlace.mode));
    applyStimulus(1'b1, 10'd1000, 10'd1000);
    lastPlace = nextPlace;
    @(negedge clk);
    checkOutput("eatenOneCycle", 32'(bus.eaten_o), 0);
    waitVisible("respawnAfterEat", 9);

    // touching edges do not collide, one pixel inside does
    applyStimulus(1'b1, lastPlace.x + 10'(PP_SIZE), lastPlace.y);
    repeat (2) begin
      @(negedge clk);
      checkOutput("edgeRightNoEat", 32'(bus.eaten_o), 0);
    end
    applyStimulus(1'b1, lastPlace.x - 10'(BALL_SIZE), lastPlace.y);
    @(negedge clk);
    checkOutput("edgeLeftNoEat", 32'(bus.eaten_o), 0);
    checkOutput("edgeStillVisible", 32'(bus.pp_visible_o), 1);
    applyStimulus(1'b1, lastPlace.x + 10'(PP_SIZE - 1), lastPlace.y);
    eatQ.push_back(lastPlace.mode);
    nextPlace = placeFrom(stepN(modelLfsr, 10));
    placeQ.push_back(nextPlace);
    @(negedge clk);
    checkOutput("edgeInsideEat", 32'(bus.eaten_o), 1);
    applyStimulus(1'b1, 10'd1000, 10'd1000);
    lastPlace = nextPlace;
    @(negedge clk);
    checkOutput("eatenOneCycle2", 32'(bus.eaten_o), 0);
    waitVisible("respawnAfterEdge", 9);

`ifdef PP_LIFETIME_EN
    // 12 SHOW cycles, then WAIT with no eaten pulse
    nextPlace = placeFrom(stepN(modelLfsr, 20));
    placeQ.push_back(nextPlace);
    repeat (11) @(negedge clk);
    checkOutput("lifeLastShow", 32'(bus.pp_visible_o), 1);
    @(negedge clk);
    checkOutput("lifeExpired", 32'(bus.pp_visible_o), 0);
    checkOutput("lifeNoEat", 32'(bus.eaten_o), 0);
    lastPlace = nextPlace;
    waitVisible("respawnAfterLife", 9);

    // collision in the expiry cycle still eats
    repeat (11) @(negedge clk);
    applyStimulus(1'b1, lastPlace.x + 10'd4, lastPlace.y + 10'd4);
    eatQ.push_back(lastPlace.mode);
    nextPlace = placeFrom(stepN(modelLfsr, 10));
    placeQ.push_back(nextPlace);
    @(negedge clk);
    checkOutput("expiryCollisionEat", 32'(bus.eaten_o), 1);
    applyStimulus(1'b1, 10'd1000, 10'd1000);
    lastPlace = nextPlace;
    @(negedge clk);
    checkOutput("eatenOneCycle3", 32'(bus.eaten_o), 0);
    waitVisible("respawnAfterExpiryEat", 9);
`else
    visCount = 0;
    repeat (101) begin
      @(negedge clk);
      if (bus.pp_visible_o === 1'b1) visCount++;
    end
    checkOutput("noLifetimeStaysVisible", 32'(visCount), 101);
`endif

    // pause in SHOW: hidden next cycle, no eat while paused, full wait after resume
    applyStimulus(1'b0, 10'd1000, 10'd1000);
    @(negedge clk);
    checkOutput("pauseHides", 32'(bus.pp_visible_o), 0);
    applyStimulus(1'b0, lastPlace.x + 10'd4, lastPlace.y + 10'd4);
    repeat (3) begin
      @(negedge clk);
      checkOutput("pauseNoEat", 32'(bus.eaten_o), 0);
    end
    applyStimulus(1'b1, 10'd1000, 10'd1000);
    lastPlace = placeFrom(stepN(modelLfsr, 8));
    placeQ.push_back(lastPlace);
    waitVisible("fullRespawnAfterPause", 9);

    // reset during SHOW with the ball on the power-up
    applyStimulus(1'b1, lastPlace.x + 10'd4, lastPlace.y + 10'd4);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rstShowVisible", 32'(bus.pp_visible_o), 0);
    checkOutput("rstShowEaten", 32'(bus.eaten_o), 0);
    checkOutput("rstShowPpX", 32'(bus.pp_x_o), 0);
    checkOutput("rstShowMode", 32'(bus.mode_o), 0);
    @(negedge clk);
    checkOutput("rstNoPendingEat", 32'(bus.eaten_o), 0);
    reset = 1'b0;
    applyStimulus(1'b1, 10'd1000, 10'd1000);
    lastPlace = placeFrom(stepN(SEED, 8));
    placeQ.push_back(lastPlace);
    waitVisible("visAfterReset2", 9);

    repeat (3) @(negedge clk);
    checkOutput("placeQDrained", 32'(placeQ.size()), 0);
    checkOutput("eatQDrained", 32'(eatQ.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/powerup_spawner.md
POWERUP_SPAWNER -- requirements
Module: powerup_spawner

Interface
REQ-001 Parameter PRESCALER, default 64999999: clk cycles per second, minus 1.
REQ-002 Parameter RESPAWN_SEC, default 5: seconds spent in WAIT before a power-up is placed.
REQ-003 Parameter LIFETIME_SEC, default 8: seconds an uneaten power-up stays visible (PP_LIFETIME_EN only).
REQ-004 Parameter PP_SIZE, default 16: power-up square side, pixels.
REQ-005 Parameter BALL_SIZE, default 8: ball square side, pixels.
REQ-006 Parameter X_MIN, default 64: left offset of the spawn area, pixels.
REQ-007 Parameter Y_MIN, default 32: top offset of the spawn area, pixels.
REQ-008 clk  input  1  system clock, all logic on rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 game_active  input  1  high while play is running.
REQ-011 ball_x  input  10  ball left edge, pixels.
REQ-012 ball_y  input  10  ball top edge, pixels.
REQ-013 pp_visible  output  1  power-up is drawn and collidable.
REQ-014 pp_x  output  10  power-up left edge.
REQ-015 pp_y  output  10  power-up top edge.
REQ-016 eaten  output  1  single-cycle pulse, power-up collected; drives the power-up timer eaten input.
REQ-017 mode  output  2  power-up type, valid whenever eaten is high; drives the power-up timer mode input.

Function
REQ-018 FSM states SHALL be WAIT, PLACE, SHOW and EAT; all outputs registered.
REQ-019 A 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) SHALL advance every cycle not in reset.
REQ-020 The seconds tick SHALL be a prescaler counting 0..PRESCALER, cleared on every state entry; each wrap increments a 4-bit seconds count, also cleared on state entry.
REQ-021 WAIT: pp_visible=0, eaten=0; go to PLACE in the cycle the seconds count reaches RESPAWN_SEC.
REQ-022 PLACE (one cycle): latch pp_x=X_MIN+lfsr[7:0], pp_y=Y_MIN+lfsr[15:8] (zero-extended), mode=lfsr[1:0] XOR lfsr[9:8]; go to SHOW.
REQ-023 SHOW: pp_visible=1; collision = ball_x<pp_x+PP_SIZE AND ball_x+BALL_SIZE>pp_x AND the same test in y, all evaluated at 11 bits (no wrap).
REQ-024 Collision sampled in SHOW SHALL go to EAT; the EAT cycle asserts eaten=1 and pp_visible=0, then returns to WAIT.
REQ-025 Latency: eaten SHALL rise exactly one cycle after the first SHOW cycle with collision true, and last exactly one cycle.
REQ-026 mode, pp_x and pp_y SHALL hold their values from PLACE until the next PLACE.
REQ-027 game_active=0 SHALL force WAIT with counters cleared from the next cycle; eaten is never asserted while game_active=0.
REQ-028 Collision and lifetime expiry in the same cycle: collision wins (EAT).
REQ-029 A collision while not in SHOW SHALL be ignored.

Reset
REQ-030 reset SHALL override all other inputs: state WAIT, prescaler and seconds count 0, LFSR 16'hACE1, pp_visible/eaten/mode/pp_x/pp_y all 0.
REQ-031 reset asserted mid-SHOW or mid-EAT SHALL give pp_visible=0 and eaten=0 from the next edge, with no pending eaten pulse afterwards.

Configuration
REQ-032 Macro PP_LIFETIME_EN defined: in SHOW, seconds count reaching LIFETIME_SEC SHALL return to WAIT with no eaten pulse.
REQ-033 PP_LIFETIME_EN undefined: SHOW is left only by collision, game_active=0 or reset; LIFETIME_SEC is unused.

Verification (PRESCALER=3, RESPAWN_SEC=2, LIFETIME_SEC=3)
REQ-034 Reset release, game_active=1, ball far away -> pp_visible rises after 8 WAIT cycles + 1 PLACE cycle; pp_x=64+lfsr[7:0] as captured.
REQ-035 In SHOW, drive ball_x=pp_x+4, ball_y=pp_y+4 -> eaten=1 for exactly one cycle next edge, pp_visible=0 that cycle, mode equals the PLACE value.
REQ-036 PP_LIFETIME_EN defined, no collision -> pp_visible falls after 12 SHOW cycles, eaten stays 0; undefined -> pp_visible stays 1 for more than 100 cycles.
REQ-037 Edge touch ball_x=pp_x+PP_SIZE -> no eaten; ball_x=pp_x+PP_SIZE-1 with y overlap -> eaten.
REQ-038 Collision coinciding with lifetime expiry (PP_LIFETIME_EN) -> eaten pulse; reset asserted in SHOW -> all outputs 0 next cycle, no eaten.
REQ-039 game_active dropped in SHOW -> pp_visible 0 next cycle; re-asserted -> full RESPAWN_SEC wait before the next PLACE.
